man_rx_frame_ctrl: RTL and testbench
====================================

Name: man_rx_frame_ctrl

Overview:
- Receive-side controller for the Manchester-to-NRZ path. Input is the Manchester line sampled once per half-bit, one sample per clk.
- Hunts for preamble plus start-frame delimiter (SFD) to fix half-bit phase, decodes bits, assembles LSB-first bytes and delimits frames.
- Reports each byte with a 1-cycle valid strobe and signals end-of-frame or error to the downstream packet logic.
- Bit coding: Man pair (0,1) = NRZ 0; (1,0) = NRZ 1. Decoded bit = first half-sample.

Parameters:
- PRE_LEN, 4, minimum preamble length in NRZ-0 bits before the SFD.
- MAX_BYTES, 16, maximum bytes per frame. Legal range 1..255.

Ports:
- clk, input, 1, system clock; one Man half-bit sample per rising edge.
- reset, input, 1, asynchronous active-high reset.
- en, input, 1, receiver enable; low forces HUNT.
- Man, input, 1, Manchester line sample.
- data_out, output, 8, last assembled byte; LSB = first received bit.
- data_valid, output, 1, 1-cycle strobe; data_out is new.
- frame_active, output, 1, high in DATA state.
- frame_end, output, 1, 1-cycle strobe; clean end of frame.
- frame_err, output, 1, 1-cycle strobe; frame aborted.
- byte_cnt, output, 8, bytes received in the current or last frame.

Behaviour:
- Reset (async, active-high): state=HUNT, prev=0, alt_cnt=0, phase=0, bit_cnt=0, shift=0. Outputs: data_out=0, data_valid=0, frame_active=0, frame_end=0, frame_err=0, byte_cnt=0. Reset mid-frame discards the partial byte and raises no strobes.
- All outputs are registered. Strobes default to 0 every cycle.
- prev register: holds the previous Man sample and updates every cycle in every state.
- en=0: next state=HUNT and alt_cnt=0. No strobes. data_out and byte_cnt hold.
- HUNT:
  - Man != prev: alt_cnt increments, saturating at 2*PRE_LEN-1.
  - Man == prev == 1 and alt_cnt >= 2*PRE_LEN-1: go to SFD. The current sample is the SFD first half.
  - Any other Man == prev: alt_cnt=0, stay in HUNT.
- SFD:
  - Man=0: go to DATA with phase=0, bit_cnt=0, byte_cnt=0.
  - Man=1: go to HUNT with alt_cnt=0, no strobe.
- DATA (frame_active=1):
  - phase=0: capture Man as the first half, set phase=1.
  - phase=1, Man != first half: shift the first half in at bit position bit_cnt, set phase=0, bit_cnt+1.
  - When bit 7 completes on this edge: data_out=assembled byte, data_valid=1, byte_cnt+1, bit_cnt=0.
  - data_valid therefore rises on the same edge that samples the second half of bit 7.
- Violation (phase=1 and Man == first half):
  - bit_cnt=0 and byte_cnt>=1: frame_end=1, go to HUNT.
  - Otherwise (partial byte, or zero bytes received): frame_err=1, go to HUNT.
  - In both cases alt_cnt=0 and byte_cnt holds its value for software readout.
- Overflow: a byte completing while byte_cnt==MAX_BYTES gives frame_err=1, no data_valid, go to HUNT.
- frame_active falls on the same edge that raises frame_end or frame_err.
- Simultaneous events: en=0 overrides a completing byte or violation, so no strobes are raised.
- A line stuck at a constant value never leaves HUNT.

Test Plan:
- Reset released, en=1, Man = 8 samples 01010101, then SFD 1,0, then byte 0xA5 LSB-first as Manchester pairs, then violation 0,0 -> data_valid exactly 1 cycle with data_out=0xA5; then frame_end=1, byte_cnt=1, frame_active back to 0.
- Preamble of only 3 zero-bits (6 samples) + SFD + data -> remains in HUNT, frame_active never 1, no strobes.
- Valid frame; violation 1,1 after 3 bits of the second byte -> byte 1 strobed, then frame_err=1, byte_cnt=1, back in HUNT.
- MAX_BYTES=2, frame carrying 3 bytes (0x01,0x02,0x03) -> data_valid for 0x01 and 0x02, then frame_err on the third byte's bit 7, no third data_valid.
- reset asserted asynchronously mid-byte (between edges) -> all outputs 0 immediately; a following full frame with 0x3C decodes correctly.
- en dropped to 0 during DATA bit 7 second half -> no data_valid and no strobes; with en=1 again, next frame 0xFF decodes.

Source files
------------

// File: rtl/man_rx_frame_ctrl.sv
// Manchester receive frame controller: locks onto preamble + SFD, decodes
// half-bit sample pairs into LSB-first bytes and delimits frames.
module man_rx_frame_ctrl #(
  parameter int PRE_LEN   = 4,
  parameter int MAX_BYTES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       Man,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_active,
  output logic       frame_end,
  output logic       frame_err,
  output logic [7:0] byte_cnt
);

  localparam int ALT_MAX = 2 * PRE_LEN - 1;
  localparam int ALT_W   = (ALT_MAX < 2) ? 1 : $clog2(ALT_MAX + 1);

  typedef enum logic [1:0] {HUNT, SFD, DATA} state_t;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [ALT_W-1:0] alt_cnt_q, alt_cnt_d;
  logic             phase_q, phase_d;
  logic             first_q, first_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_active_q, frame_active_d;
  logic             frame_end_q, frame_end_d;
  logic             frame_err_q, frame_err_d;

  // NOTE: every _d gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    prev_d       = Man;
    alt_cnt_d    = alt_cnt_q;
    phase_d      = phase_q;
    first_d      = first_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    byte_cnt_d   = byte_cnt_q;
    data_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    frame_err_d  = 1'b0;

    if (!en) begin
      state_d   = HUNT;
      alt_cnt_d = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (Man != prev_q) begin
            if (alt_cnt_q != ALT_W'(ALT_MAX)) alt_cnt_d = alt_cnt_q + 1'b1;
          end else if (Man && alt_cnt_q == ALT_W'(ALT_MAX)) begin
            state_d = SFD;  // this sample is the first half of the SFD
          end else begin
            alt_cnt_d = '0;
          end
        end
        SFD: begin
          if (!Man) begin
            state_d    = DATA;
            phase_d    = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end else begin
            state_d   = HUNT;
            alt_cnt_d = '0;
          end
        end
        DATA: begin
          if (!phase_q) begin
            first_d = Man;
            phase_d = 1'b1;
          end else if (Man != first_q) begin
            phase_d            = 1'b0;
            shift_d[bit_cnt_q] = first_q;
            bit_cnt_d          = bit_cnt_q + 3'd1;  // wraps to 0 after bit 7
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == 8'(MAX_BYTES)) begin
                frame_err_d = 1'b1;
                state_d     = HUNT;
                alt_cnt_d   = '0;
              end else begin
                data_out_d   = {first_q, shift_q[6:0]};
                data_valid_d = 1'b1;
                byte_cnt_d   = byte_cnt_q + 8'd1;
              end
            end
          end else begin
            // Missing mid-bit transition: clean end only on a byte boundary.
            if (bit_cnt_q == 3'd0 && byte_cnt_q != 8'd0) frame_end_d = 1'b1;
            else                                         frame_err_d = 1'b1;
            phase_d   = 1'b0;
            state_d   = HUNT;
            alt_cnt_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    frame_active_d = (state_d == DATA);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HUNT;
      prev_q         <= 1'b0;
      alt_cnt_q      <= '0;
      phase_q        <= 1'b0;
      first_q        <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      data_out_q     <= '0;
      byte_cnt_q     <= '0;
      data_valid_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      alt_cnt_q      <= alt_cnt_d;
      phase_q        <= phase_d;
      first_q        <= first_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      data_out_q     <= data_out_d;
      byte_cnt_q     <= byte_cnt_d;
      data_valid_q   <= data_valid_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign frame_active = frame_active_q;
  assign frame_end    = frame_end_q;
  assign frame_err    = frame_err_q;
  assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_man_rx_frame_ctrl.sv
// Directed bench for man_rx_frame_ctrl: expected bytes go into a queue as
// they are driven and are popped whenever the receiver strobes data_valid.
module tb_man_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       Man;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_active;
  logic       frame_end;
  logic       frame_err;
  logic [7:0] byte_cnt;

  man_rx_frame_ctrl #(.PRE_LEN(4), .MAX_BYTES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .Man          (Man),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_active (frame_active),
    .frame_end    (frame_end),
    .frame_err    (frame_err),
    .byte_cnt     (byte_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         end_seen, err_seen, active_seen;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    end_seen    = 0;
    err_seen    = 0;
    active_seen = 0;
  endtask

  // Drive one half-bit sample, then observe the registered outputs after the edge.
  task automatic sample(input logic b);
    @(negedge clk);
    Man = b;
    @(posedge clk);
    #1;
    end_seen    += int'(frame_end);
    err_seen    += int'(frame_err);
    active_seen += int'(frame_active);
    if (data_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 8'(data_valid), 8'd0);
      else                   check("byte", data_out, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sample(1'b0);
  endtask

  task automatic preamble_sfd(input int zero_bits);
    for (int i = 0; i < zero_bits; i++) begin
      sample(1'b0);
      sample(1'b1);
    end
    sample(1'b1);
    sample(1'b0);
  endtask

  task automatic man_bit(input logic b);
    sample(b);
    sample(~b);
  endtask

  task automatic man_byte(input logic [7:0] v, input bit push);
    if (push) exp_q.push_back(v);
    for (int i = 0; i < 8; i++) man_bit(v[i]);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    Man   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_byte_cnt", byte_cnt, 8'h00);
    check("rst_strobes", {4'd0, data_valid, frame_active, frame_end, frame_err}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;

    // Clean single-byte frame ended by a 0,0 violation on a byte boundary.
    clear_seen();
    idle(3);
    preamble_sfd(4);
    man_byte(8'hA5, 1'b1);
    check("t1_active_during", 8'(active_seen > 0), 8'd1);
    sample(1'b0);
    sample(1'b0);
    check("t1_frame_end", 8'(frame_end), 8'd1);
    check("t1_active_off", 8'(frame_active), 8'd0);
    check("t1_byte_cnt", byte_cnt, 8'd1);
    check("t1_data_out", data_out, 8'hA5);
    check("t1_err_none", 8'(err_seen), 8'd0);
    check("t1_queue_empty", 8'(exp_q.size()), 8'd0);

    // Preamble one zero-bit short: receiver must stay in HUNT.
    clear_seen();
    idle(3);
    preamble_sfd(3);
    man_byte(8'hA5, 1'b0);
    sample(1'b0);
    sample(1'b0);
    idle(2);
    check("t2_never_active", 8'(active_seen), 8'd0);
    check("t2_no_end", 8'(end_seen), 8'd0);
    check("t2_no_err", 8'(err_seen), 8'd0);
    check("t2_byte_cnt_hold", byte_cnt, 8'd1);

    // Violation 1,1 three bits into the second byte.
    clear_seen();
    idle(3);
    preamble_sfd(4);
    man_byte(8'h5A, 1'b1);
    man_bit(1'b1);
    man_bit(1'b1);
    man_bit(1'b0);
    sample(1'b1);
    sample(1'b1);
    check("t3_frame_err", 8'(frame_err), 8'd1);
    check("t3_active_off", 8'(frame_active), 8'd0);
    check("t3_byte_cnt", byte_cnt, 8'd1);
    check("t3_no_end", 8'(end_seen), 8'd0);
    check("t3_queue_empty", 8'(exp_q.size()), 8'd0);

    // Overflow with MAX_BYTES=2: third byte aborts the frame at its bit 7.
    clear_seen();
    idle(3);
    preamble_sfd(4);
    man_byte(8'h01, 1'b1);
    man_byte(8'h02, 1'b1);
    man_byte(8'h03, 1'b0);
    check("t4_frame_err", 8'(frame_err), 8'd1);
    check("t4_no_valid", 8'(data_valid), 8'd0);
    check("t4_byte_cnt", byte_cnt, 8'd2);
    check("t4_data_out", data_out, 8'h02);
    check("t4_active_off", 8'(frame_active), 8'd0);
    check("t4_err_count", 8'(err_seen), 8'd1);
    check("t4_queue_empty", 8'(exp_q.size()), 8'd0);

    // Asynchronous reset between edges in the middle of a byte.
    clear_seen();
    idle(3);
    preamble_sfd(4);
    for (int i = 0; i < 4; i++) man_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_data_out", data_out, 8'h00);
    check("t5_rst_byte_cnt", byte_cnt, 8'h00);
    check("t5_rst_strobes", {4'd0, data_valid, frame_active, frame_end, frame_err}, 8'h00);
    #1;
    reset = 1'b0;
    idle(3);
    preamble_sfd(4);
    man_byte(8'h3C, 1'b1);
    sample(1'b0);
    sample(1'b0);
    check("t5_frame_end", 8'(end_seen), 8'd1);
    check("t5_byte_cnt", byte_cnt, 8'd1);
    check("t5_data_out", data_out, 8'h3C);
    check("t5_no_err", 8'(err_seen), 8'd0);

    // en dropped on the second half of bit 7: byte and frame silently dropped.
    clear_seen();
    idle(3);
    preamble_sfd(4);
    for (int i = 0; i < 7; i++) man_bit(1'b1);
    sample(1'b1);
    en = 1'b0;
    sample(1'b0);
    check("t6_no_valid", 8'(data_valid), 8'd0);
    check("t6_active_off", 8'(frame_active), 8'd0);
    idle(3);
    check("t6_byte_cnt_hold", byte_cnt, 8'd0);
    check("t6_no_strobes", 8'(end_seen + err_seen), 8'd0);
    en = 1'b1;
    idle(3);
    preamble_sfd(4);
    man_byte(8'hFF, 1'b1);
    sample(1'b0);
    sample(1'b0);
    check("t6_frame_end", 8'(end_seen), 8'd1);
    check("t6_byte_cnt", byte_cnt, 8'd1);
    check("t6_data_out", data_out, 8'hFF);
    check("t6_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
